// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: instruction-memory port, output word handshake and redirect.
// The master modport is the fetch controller side; the slave modport is the memory/consumer side.
interface fetch_controller_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc,
        input  imem_data, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc,
        output imem_data, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one-deep output register fed from a combinational imem.
// Optional macro FETCH_TRACE_EN compiles in a simulation trace of handshakes and halts.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    fetch_controller_if.master  bus,
    output logic                halted,
    output logic                error,
    output logic [31:0]         fetch_count
);
    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] opc_q, opc_n;
    logic        valid_q, valid_n;
    logic        err_n;
    logic [31:0] count_n;
    logic        handshake;
    logic        load;

    assign handshake = valid_q && bus.out_ready;
    assign load      = (state == RUN) && (!valid_q || bus.out_ready);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_q     <= '0;
            opc_q       <= '0;
            valid_q     <= 1'b0;
            error       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_q     <= instr_n;
            opc_q       <= opc_n;
            valid_q     <= valid_n;
            error       <= err_n;
            fetch_count <= count_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a hold default first so no path infers a latch.
        state_n = state;
        pc_n    = pc;
        instr_n = instr_q;
        opc_n   = opc_q;
        valid_n = valid_q;
        err_n   = error;
        count_n = fetch_count;

        if (bus.redirect_valid) begin
            // Redirect wins outright; a coincident handshake is dropped uncounted.
            state_n = RUN;
            pc_n    = bus.redirect_pc;
            valid_n = 1'b0;
            err_n   = 1'b0;
        end else begin
            if (handshake) begin
                valid_n = 1'b0;
                if (fetch_count != 32'hFFFF_FFFF) count_n = fetch_count + 32'd1;
            end
            unique case (state)
                IDLE: state_n = RUN;
                RUN: begin
                    if (load) begin
                        if (pc < DEPTH) begin
                            instr_n = bus.imem_data;
                            opc_n   = pc;
                            valid_n = 1'b1;
                            if (bus.imem_data == HALT_WORD) state_n = HALT;
                            else                            pc_n    = pc + 32'd1;
                        end else begin
                            valid_n = 1'b0;
                            err_n   = 1'b1;
                            state_n = HALT;
                        end
                    end
                end
                HALT: ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.imem_addr = pc;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = opc_q;
    assign halted        = (state == HALT);

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (handshake && !bus.redirect_valid)
                $display("FETCH pc=%h instr=%h", opc_q, instr_q);
            if (state != HALT && state_n == HALT)
                $display(err_n ? "FETCH ERROR" : "FETCH HALT");
        end
    end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a scoreboard queue holds expected output words,
// a negedge monitor pops one per accepted handshake; stimulus checks status directly.
module tb_fetch_controller;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    logic        clk;
    logic        reset;
    logic        halted;
    logic        error;
    logic [31:0] fetch_count;
    logic [31:0] mem [32];
    word_t       exp_q[$];
    int          n_checks;
    int          n_fail;

    fetch_controller_if bus ();

    fetch_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .halted      (halted),
        .error       (error),
        .fetch_count (fetch_count)
    );

    assign bus.imem_data = (bus.imem_addr < 32'd32) ? mem[bus.imem_addr[4:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        word_t w;
        w.pc    = pc;
        w.instr = mem[pc[4:0]];
        exp_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (!halted && n < 40) begin
            step();
            n++;
        end
        check({name, "_reached_halt"}, {31'd0, halted}, 32'd1);
    endtask

    // Monitor: every accepted, non-redirected handshake must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got pc %h instr %h with empty scoreboard",
                         bus.out_pc, bus.out_instr);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("sb_pc", bus.out_pc, w.pc);
                check("sb_instr", bus.out_instr, w.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0013 + 32'(i << 8);
        mem[0]  = 32'h0000_0013;
        mem[1]  = 32'h0000_0093;
        mem[2]  = 32'hFFFF_FFFF;
        mem[5]  = 32'h0050_0513;
        mem[6]  = 32'h00A0_0593;
        mem[7]  = 32'hFFFF_FFFF;
        mem[30] = 32'h01E0_0613;
        mem[31] = 32'h01F0_0693;

        reset              = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) step();
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);

        // Straight-line program ending on the halt word.
        push(0); push(1); push(2);
        reset = 1'b0;
        step();
        check("idle_no_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("run_pc0", bus.out_pc, 32'd0);
        step();
        check("run_pc1", bus.out_pc, 32'd1);
        step();
        check("run_pc2", bus.out_pc, 32'd2);
        check("halt_entered", {31'd0, halted}, 32'd1);
        step();
        check("halt_valid_cleared", {31'd0, bus.out_valid}, 32'd0);
        check("halt_error", {31'd0, error}, 32'd0);
        check("halt_count", fetch_count, 32'd3);
        check("halt_addr_held", bus.imem_addr, 32'd2);

        // Backpressure: hold word 0 for three cycles.
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        step();
        bus.redirect_valid = 1'b0;
        check("redir_halted_low", {31'd0, halted}, 32'd0);
        step();
        push(0);
        for (int i = 0; i < 3; i++) begin
            check("stall_pc", bus.out_pc, 32'd0);
            check("stall_instr", bus.out_instr, 32'h0000_0013);
            check("stall_addr", bus.imem_addr, 32'd1);
            check("stall_count", fetch_count, 32'd3);
            step();
        end
        push(1); push(2);
        bus.out_ready = 1'b1;
        wait_halt("stall");
        step();
        check("stall_final_count", fetch_count, 32'd6);

        // Redirect coincident with the handshake of word 2.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        step();
        bus.redirect_valid = 1'b0;
        push(0); push(1);
        repeat (3) step();
        check("pre_redir_pc", bus.out_pc, 32'd2);
        check("pre_redir_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd5;
        step();
        bus.redirect_valid = 1'b0;
        check("redir_valid_low", {31'd0, bus.out_valid}, 32'd0);
        check("redir_addr", bus.imem_addr, 32'd5);
        check("redir_count", fetch_count, 32'd8);
        push(5); push(6); push(7);
        step();
        check("redir_first_pc", bus.out_pc, 32'd5);
        wait_halt("redir");
        step();
        check("redir_final_count", fetch_count, 32'd11);

        // Run off the end of memory from word 30.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd30;
        step();
        bus.redirect_valid = 1'b0;
        push(30); push(31);
        wait_halt("range");
        step();
        check("range_error", {31'd0, error}, 32'd1);
        check("range_valid", {31'd0, bus.out_valid}, 32'd0);
        check("range_count", fetch_count, 32'd13);

        // Redirect out of the error halt, then async reset mid-stream.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        step();
        bus.redirect_valid = 1'b0;
        check("recover_error", {31'd0, error}, 32'd0);
        check("recover_halted", {31'd0, halted}, 32'd0);
        push(0);
        step();
        check("recover_pc0", bus.out_pc, 32'd0);
        step();
        check("pending_pc1", bus.out_pc, 32'd1);
        check("pending_count", fetch_count, 32'd14);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_instr", bus.out_instr, 32'd0);
        check("async_pc", bus.out_pc, 32'd0);
        check("async_addr", bus.imem_addr, 32'd0);
        check("async_error", {31'd0, error}, 32'd0);
        check("async_halted", {31'd0, halted}, 32'd0);
        check("async_count", fetch_count, 32'd0);
        repeat (2) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, word index loaded into PC on reset.
REQ-002: Parameter MEM_DEPTH, default 32, number of valid instruction-memory words; indices 0..MEM_DEPTH-1.
REQ-003: Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that terminates fetch.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: imem_addr  output  32  word index driven to the instruction memory; equals PC combinationally.
REQ-007: imem_data  input  32  combinational read data from the instruction memory for imem_addr.
REQ-008: out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-009: out_ready  input  1  consumer accepts the output word this cycle.
REQ-010: out_instr  output  32  fetched instruction word.
REQ-011: out_pc  output  32  word index out_instr was fetched from.
REQ-012: redirect_valid  input  1  load redirect_pc into PC and flush output this cycle.
REQ-013: redirect_pc  input  32  new fetch word index.
REQ-014: halted  output  1  high while in HALT state.
REQ-015: error  output  1  sticky; PC left the valid range.
REQ-016: fetch_count  output  32  number of instructions accepted by the consumer; saturates at 32'hFFFF_FFFF.

Function
REQ-017: States: IDLE, RUN, HALT; IDLE lasts exactly one cycle after reset deassertion, then RUN.
REQ-018: Load condition: state RUN and (out_valid==0 or out_ready==1).
REQ-019: On load with PC < MEM_DEPTH: out_instr<=imem_data, out_pc<=PC, out_valid<=1, PC<=PC+1; one-cycle fetch latency from PC to out_valid.
REQ-020: Loaded word equal to HALT_WORD: word still presented on output, PC not incremented, state<=HALT.
REQ-021: On load with PC >= MEM_DEPTH: no word issued, out_valid<=0, error<=1, state<=HALT.
REQ-022: out_valid with out_ready low: out_instr, out_pc, out_valid held stable; PC held.
REQ-023: In HALT: no fetch; out_valid cleared on its handshake (out_valid&out_ready); PC held.
REQ-024: fetch_count increments by 1 on each out_valid&out_ready cycle, in any state, saturating at maximum.
REQ-025: redirect_valid has priority over every other event in the same cycle: PC<=redirect_pc, out_valid<=0, error<=0, state<=RUN; a coincident handshake is discarded and not counted.
REQ-026: Redirect in IDLE is applied and state goes to RUN.
REQ-027: PC arithmetic is 32-bit modulo 2^32; the range check of REQ-021 applies before any wrap can be fetched.

Reset
REQ-028: While reset is high, regardless of clk: PC=RESET_PC, state=IDLE, out_valid=0, out_instr=0, out_pc=0, error=0, halted=0, fetch_count=0.
REQ-029: Reset asserted mid-operation discards any pending output word immediately; no handshake completes in a reset cycle.

Configuration
REQ-030: Macro FETCH_TRACE_EN defined: on every output handshake the block prints via simulation display "FETCH pc=<out_pc hex> instr=<out_instr hex>", and prints "FETCH HALT" or "FETCH ERROR" on entering HALT.
REQ-031: Macro FETCH_TRACE_EN undefined: no display statements compiled; port and cycle behaviour identical.

Verification
REQ-032: Memory 0:00000013, 1:00000093, 2:FFFFFFFF, out_ready=1 -> out_pc 0,1,2 on consecutive cycles after IDLE, then halted=1, error=0, fetch_count=3.
REQ-033: out_ready=0 for 3 cycles while out_valid=1 at out_pc=0 -> out_instr/out_pc stable, imem_addr stays 1, fetch_count unchanged.
REQ-034: RESET_PC=30, no HALT_WORD in memory, out_ready=1 -> words 30,31 issued, then error=1, halted=1, out_valid=0, fetch_count=2.
REQ-035: redirect_valid=1, redirect_pc=5 in the same cycle as a handshake at out_pc=2 -> next cycle out_valid=0, imem_addr=5, fetch_count not incremented; following cycle out_pc=5.
REQ-036: In HALT with error=1, redirect_pc=0 -> error=0, halted=0, fetch resumes at 0; reset asserted asynchronously mid-stream -> all outputs zero before next clk edge.
